// File: rtl/spi_oled_tx.sv
// spi_oled_tx: SPI transmit master for the OLED panel path.
// Takes words over a valid/ready handshake and shifts them out MSB-first on
// DIN. CS, DC, SCLK and DIN are all registered, and SCLK is divided from CLK.
// Optional feature macro: SPI_BURST_EN. When it is defined, a new word can be
// accepted in the last HOLD cycle, so CS stays low between consecutive words.
module spi_oled_tx #(
    parameter int WIDTH  = 8,
    parameter int DIV    = 40,
    parameter int CS_GAP = 2,
    parameter int CPOL   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_dc_in,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_done,
    output logic             o_busy,
    output logic             o_sclk,
    output logic             o_cs,
    output logic             o_dc,
    output logic             o_din
);
    localparam int   DCW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int   BCW      = $clog2(WIDTH + 1);
    localparam int   GCW      = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic IDLE_LVL = (CPOL != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_TRAIL,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           r_state,   w_state_next;
    logic [DCW-1:0]   r_div_cnt, w_div_cnt_next;
    logic [BCW-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic [GCW-1:0]   r_gap_cnt, w_gap_cnt_next;
    logic [WIDTH-1:0] r_shift,   w_shift_next;
    logic             r_sclk,    w_sclk_next;
    logic             r_cs,      w_cs_next;
    logic             r_dc,      w_dc_next;
    logic             r_din,     w_din_next;
    logic             r_done,    w_done_next;
    logic             w_ready;
    logic             w_phase_end;
    logic             w_last_bit;
    logic             w_gap_end;
    logic [WIDTH-1:0] w_shifted;

    assign w_phase_end = (r_div_cnt == DCW'(DIV - 1));
    assign w_last_bit  = (r_bit_cnt == BCW'(WIDTH - 1));
    assign w_gap_end   = (r_gap_cnt == GCW'(CS_GAP - 1));
    assign w_shifted   = r_shift << 1;

    // Next-state and next-output decode; an accepted word overrides the state's own plan.
    always_comb begin
        w_state_next   = r_state;
        w_div_cnt_next = r_div_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_gap_cnt_next = r_gap_cnt;
        w_shift_next   = r_shift;
        w_sclk_next    = r_sclk;
        w_cs_next      = r_cs;
        w_dc_next      = r_dc;
        w_din_next     = r_din;
        w_done_next    = 1'b0;
        w_ready        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready    = 1'b1;
                w_din_next = 1'b0;
            end
            S_LEAD: begin
                if (w_phase_end) begin
                    w_state_next   = S_TRAIL;
                    w_sclk_next    = ~IDLE_LVL;
                    w_div_cnt_next = '0;
                end else begin
                    w_div_cnt_next = r_div_cnt + DCW'(1);
                end
            end
            S_TRAIL: begin
                if (w_phase_end) begin
                    w_sclk_next    = IDLE_LVL;
                    w_div_cnt_next = '0;
                    w_bit_cnt_next = r_bit_cnt + BCW'(1);
                    if (w_last_bit) begin
                        // Last bit stays on DIN through HOLD.
                        w_state_next = S_HOLD;
                    end else begin
                        w_state_next = S_LEAD;
                        w_shift_next = w_shifted;
                        w_din_next   = w_shifted[WIDTH-1];
                    end
                end else begin
                    w_div_cnt_next = r_div_cnt + DCW'(1);
                end
            end
            S_HOLD: begin
`ifdef SPI_BURST_EN
                w_ready = w_phase_end;
`endif
                if (w_phase_end) begin
                    w_done_next    = 1'b1;
                    w_cs_next      = 1'b1;
                    w_din_next     = 1'b0;
                    w_div_cnt_next = '0;
                    w_gap_cnt_next = '0;
                    w_state_next   = (CS_GAP == 0) ? S_IDLE : S_GAP;
                end else begin
                    w_div_cnt_next = r_div_cnt + DCW'(1);
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + GCW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        if (i_valid && w_ready) begin
            w_state_next   = S_LEAD;
            w_shift_next   = i_data;
            w_dc_next      = i_dc_in;
            w_din_next     = i_data[WIDTH-1];
            w_cs_next      = 1'b0;
            w_sclk_next    = IDLE_LVL;
            w_div_cnt_next = '0;
            w_bit_cnt_next = '0;
        end
    end

    // State, counters and the pin-driving registers; reset aborts any word in flight.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_shift   <= '0;
            r_sclk    <= IDLE_LVL;
            r_cs      <= 1'b1;
            r_dc      <= 1'b0;
            r_din     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_div_cnt <= w_div_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_gap_cnt <= w_gap_cnt_next;
            r_shift   <= w_shift_next;
            r_sclk    <= w_sclk_next;
            r_cs      <= w_cs_next;
            r_dc      <= w_dc_next;
            r_din     <= w_din_next;
            r_done    <= w_done_next;
        end
    end

    assign o_ready = w_ready & i_rst_n;
    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = r_done;
    assign o_sclk  = r_sclk;
    assign o_cs    = r_cs;
    assign o_dc    = r_dc;
    assign o_din   = r_din;

endmodule

// File: tb/tb_spi_oled_tx.sv
// Bench for spi_oled_tx. It runs three instances in parallel:
// inst 0 is WIDTH=8, DIV=2, CPOL=0; inst 1 is WIDTH=8, DIV=2, CPOL=1;
// inst 2 is WIDTH=16, DIV=1, CPOL=0. All three use CS_GAP=2.
// The bench samples DUT outputs on the falling edge and drives inputs just
// after the rising edge. Cycle numbers count falling-edge samples.
module tb_spi_oled_tx;
    localparam int NI = 3;
    localparam int P_W    [NI] = '{8, 8, 16};
    localparam int P_D    [NI] = '{2, 2, 1};
    localparam int P_CPOL [NI] = '{0, 1, 0};
    localparam int P_GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data  [NI];
    logic        dc_in [NI];
    logic        valid [NI];
    logic        ready [NI];
    logic        done  [NI];
    logic        busy  [NI];
    logic        sclk  [NI];
    logic        cs    [NI];
    logic        dc    [NI];
    logic        din   [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        spi_oled_tx #(
            .WIDTH (P_W[gi]),
            .DIV   (P_D[gi]),
            .CS_GAP(P_GAP),
            .CPOL  (P_CPOL[gi])
        ) u_dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .i_data (data[gi][P_W[gi]-1:0]),
            .i_dc_in(dc_in[gi]),
            .i_valid(valid[gi]),
            .o_ready(ready[gi]),
            .o_done (done[gi]),
            .o_busy (busy[gi]),
            .o_sclk (sclk[gi]),
            .o_cs   (cs[gi]),
            .o_dc   (dc[gi]),
            .o_din  (din[gi])
        );
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Per-instance word queue and observation records.
    logic [15:0] q_word [NI][4];
    logic        q_dc   [NI][4];
    int          q_n    [NI];
    int          q_head [NI];
    int          nacc   [NI];
    int          acc_t  [NI][4];
    int          ndone  [NI];
    int          done_t [NI][4];
    int          nrise  [NI];
    int          rise_t [NI][4];
    int          nfall  [NI];
    int          fall_t [NI][4];
    int          cs_low [NI];
    int          nbits  [NI];
    logic [31:0] bits   [NI];
    int          first_trail [NI];
    logic        dc_seen [NI];
    int          rdy_t  [NI];
    logic        prev_cs   [NI];
    logic        prev_sclk [NI];

    task automatic clear_stats();
        for (int i = 0; i < NI; i++) begin
            q_n[i] = 0; q_head[i] = 0; nacc[i] = 0; ndone[i] = 0;
            nrise[i] = 0; nfall[i] = 0; cs_low[i] = 0; nbits[i] = 0;
            bits[i] = '0; first_trail[i] = -1; dc_seen[i] = 1'bx; rdy_t[i] = -1;
            for (int k = 0; k < 4; k++) begin
                acc_t[i][k] = -1; done_t[i][k] = -1; rise_t[i][k] = -1; fall_t[i][k] = -1;
            end
            prev_cs[i]   = cs[i];
            prev_sclk[i] = sclk[i];
        end
    endtask

    task automatic push(input int i, input logic [15:0] w, input logic d);
        q_word[i][q_n[i]] = w;
        q_dc[i][q_n[i]]   = d;
        q_n[i]++;
    endtask

    // One clock: observe on the falling edge, then drive just after the next rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (valid[i] && ready[i]) begin
                if (nacc[i] < 4) acc_t[i][nacc[i]] = cyc;
                nacc[i]++;
                q_head[i]++;
            end
            if (done[i]) begin
                if (ndone[i] < 4) done_t[i][ndone[i]] = cyc;
                ndone[i]++;
                $display("word done: inst %0d cycle %0d bits_so_far 0x%0h", i, cyc, bits[i]);
            end
            if (ready[i] && ndone[i] > 0 && rdy_t[i] < 0) rdy_t[i] = cyc;
            if (!cs[i]) cs_low[i]++;
            if (cs[i] && !prev_cs[i]) begin
                if (nrise[i] < 4) rise_t[i][nrise[i]] = cyc;
                nrise[i]++;
            end
            if (!cs[i] && prev_cs[i]) begin
                if (nfall[i] < 4) fall_t[i][nfall[i]] = cyc;
                nfall[i]++;
            end
            if (sclk[i] != prev_sclk[i] && sclk[i] != (P_CPOL[i] != 0)) begin
                bits[i] = {bits[i][30:0], din[i]};
                if (nbits[i] == 0) begin
                    first_trail[i] = cyc;
                    dc_seen[i]     = dc[i];
                end
                nbits[i]++;
            end
            prev_cs[i]   = cs[i];
            prev_sclk[i] = sclk[i];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (q_head[i] < q_n[i]) begin
                valid[i] = 1'b1;
                data[i]  = q_word[i][q_head[i]];
                dc_in[i] = q_dc[i][q_head[i]];
            end else begin
                valid[i] = 1'b0;
                data[i]  = 16'hFFFF;
                dc_in[i] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NI; i++) begin
            checks++; if (cs[i] !== 1'b1) begin errors++; $display("FAIL rst_cs inst %0d got %b want 1", i, cs[i]); end
            checks++; if (sclk[i] !== (P_CPOL[i] != 0)) begin errors++; $display("FAIL rst_sclk inst %0d got %b want %0d", i, sclk[i], P_CPOL[i]); end
            checks++; if (din[i] !== 1'b0) begin errors++; $display("FAIL rst_din inst %0d got %b want 0", i, din[i]); end
            checks++; if (dc[i] !== 1'b0) begin errors++; $display("FAIL rst_dc inst %0d got %b want 0", i, dc[i]); end
            checks++; if (done[i] !== 1'b0) begin errors++; $display("FAIL rst_done inst %0d got %b want 0", i, done[i]); end
            checks++; if (busy[i] !== 1'b0) begin errors++; $display("FAIL rst_busy inst %0d got %b want 0", i, busy[i]); end
            checks++; if (ready[i] !== 1'b0) begin errors++; $display("FAIL rst_ready inst %0d got %b want 0", i, ready[i]); end
        end
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NI; i++) begin
            checks++; if (ready[i] !== 1'b1) begin errors++; $display("FAIL idle_ready inst %0d got %b want 1", i, ready[i]); end
        end
    endtask

    // 0xA5 with DC=1 on both 8-bit instances, one per SCLK polarity.
    task automatic test_basic();
        clear_stats();
        push(0, 16'h00A5, 1'b1);
        push(1, 16'h00A5, 1'b1);
        repeat (50) step();
        for (int i = 0; i < 2; i++) begin
            checks++; if (nbits[i] != 8) begin errors++; $display("FAIL basic_nbits inst %0d got %0d want 8", i, nbits[i]); end
            checks++; if (bits[i][7:0] !== 8'hA5) begin errors++; $display("FAIL basic_bits inst %0d got 0x%0h want 0xa5", i, bits[i][7:0]); end
            checks++; if (cs_low[i] != 34) begin errors++; $display("FAIL basic_cs_low inst %0d got %0d want 34", i, cs_low[i]); end
            checks++; if (ndone[i] != 1) begin errors++; $display("FAIL basic_ndone inst %0d got %0d want 1", i, ndone[i]); end
            checks++; if (done_t[i][0] - acc_t[i][0] != 35) begin errors++; $display("FAIL basic_done_t inst %0d got %0d want 35", i, done_t[i][0] - acc_t[i][0]); end
            checks++; if (rdy_t[i] - acc_t[i][0] != 37) begin errors++; $display("FAIL basic_ready_t inst %0d got %0d want 37", i, rdy_t[i] - acc_t[i][0]); end
            checks++; if (first_trail[i] - acc_t[i][0] != 3) begin errors++; $display("FAIL basic_trail0 inst %0d got %0d want 3", i, first_trail[i] - acc_t[i][0]); end
            checks++; if (dc_seen[i] !== 1'b1) begin errors++; $display("FAIL basic_dc inst %0d got %b want 1", i, dc_seen[i]); end
            checks++; if (sclk[i] !== (P_CPOL[i] != 0)) begin errors++; $display("FAIL basic_sclk_idle inst %0d got %b want %0d", i, sclk[i], P_CPOL[i]); end
            checks++; if (din[i] !== 1'b0) begin errors++; $display("FAIL basic_din_idle inst %0d got %b want 0", i, din[i]); end
        end
    endtask

    // 0x8001 with DC=0 on the 16-bit, DIV=1 instance.
    task automatic test_wide();
        clear_stats();
        push(2, 16'h8001, 1'b0);
        repeat (50) step();
        checks++; if (nbits[2] != 16) begin errors++; $display("FAIL wide_nbits got %0d want 16", nbits[2]); end
        checks++; if (bits[2][15:0] !== 16'h8001) begin errors++; $display("FAIL wide_bits got 0x%0h want 0x8001", bits[2][15:0]); end
        checks++; if (cs_low[2] != 33) begin errors++; $display("FAIL wide_cs_low got %0d want 33", cs_low[2]); end
        checks++; if (ndone[2] != 1) begin errors++; $display("FAIL wide_ndone got %0d want 1", ndone[2]); end
        checks++; if (done_t[2][0] - acc_t[2][0] != 34) begin errors++; $display("FAIL wide_done_t got %0d want 34", done_t[2][0] - acc_t[2][0]); end
        checks++; if (rdy_t[2] - acc_t[2][0] != 36) begin errors++; $display("FAIL wide_ready_t got %0d want 36", rdy_t[2] - acc_t[2][0]); end
        checks++; if (first_trail[2] - acc_t[2][0] != 2) begin errors++; $display("FAIL wide_trail0 got %0d want 2", first_trail[2] - acc_t[2][0]); end
        checks++; if (dc_seen[2] !== 1'b0) begin errors++; $display("FAIL wide_dc got %b want 0", dc_seen[2]); end
    endtask

    // Reset asserted ten cycles into a word aborts it; a fresh word then completes.
    task automatic test_reset_mid();
        int t0;
        clear_stats();
        push(0, 16'h0096, 1'b1);
        for (int k = 0; k < 5 && nacc[0] == 0; k++) step();
        checks++; if (nacc[0] != 1) begin errors++; $display("FAIL mid_accept got %0d want 1", nacc[0]); end
        t0 = acc_t[0][0];
        for (int k = 0; k < 20 && cyc < t0 + 9; k++) step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        checks++; if (cs[0] !== 1'b1) begin errors++; $display("FAIL mid_cs got %b want 1", cs[0]); end
        checks++; if (sclk[0] !== 1'b0) begin errors++; $display("FAIL mid_sclk got %b want 0", sclk[0]); end
        checks++; if (din[0] !== 1'b0) begin errors++; $display("FAIL mid_din got %b want 0", din[0]); end
        checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy[0]); end
        checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL mid_done got %b want 0", done[0]); end
        checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL mid_ready got %b want 0", ready[0]); end
        rst_n = 1'b1;
        repeat (40) step();
        checks++; if (ndone[0] != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", ndone[0]); end
        clear_stats();
        push(0, 16'h005A, 1'b0);
        repeat (50) step();
        checks++; if (ndone[0] != 1) begin errors++; $display("FAIL fresh_ndone got %0d want 1", ndone[0]); end
        checks++; if (bits[0][7:0] !== 8'h5A) begin errors++; $display("FAIL fresh_bits got 0x%0h want 0x5a", bits[0][7:0]); end
        checks++; if (cs_low[0] != 34) begin errors++; $display("FAIL fresh_cs_low got %0d want 34", cs_low[0]); end
        checks++; if (done_t[0][0] - acc_t[0][0] != 35) begin errors++; $display("FAIL fresh_done_t got %0d want 35", done_t[0][0] - acc_t[0][0]); end
    endtask

`ifdef SPI_BURST_EN
    // VALID held over 0x3C then 0xC3: the second word is taken in the last HOLD cycle.
    task automatic test_burst();
        clear_stats();
        push(0, 16'h003C, 1'b0);
        push(0, 16'h00C3, 1'b1);
        repeat (90) step();
        checks++; if (ndone[0] != 2) begin errors++; $display("FAIL burst_ndone got %0d want 2", ndone[0]); end
        checks++; if (nbits[0] != 16) begin errors++; $display("FAIL burst_nbits got %0d want 16", nbits[0]); end
        checks++; if (bits[0][15:0] !== 16'h3CC3) begin errors++; $display("FAIL burst_bits got 0x%0h want 0x3cc3", bits[0][15:0]); end
        checks++; if (acc_t[0][1] - acc_t[0][0] != 34) begin errors++; $display("FAIL burst_acc_gap got %0d want 34", acc_t[0][1] - acc_t[0][0]); end
        checks++; if (done_t[0][1] - done_t[0][0] != 34) begin errors++; $display("FAIL burst_done_gap got %0d want 34", done_t[0][1] - done_t[0][0]); end
        checks++; if (nfall[0] != 1) begin errors++; $display("FAIL burst_cs_falls got %0d want 1", nfall[0]); end
        checks++; if (nrise[0] != 1) begin errors++; $display("FAIL burst_cs_rises got %0d want 1", nrise[0]); end
        checks++; if (dc[0] !== 1'b1) begin errors++; $display("FAIL burst_dc got %b want 1", dc[0]); end
    endtask
`else
    // VALID held over 0x3C then 0xC3: CS rises between words and the second word waits for READY.
    task automatic test_back_to_back();
        clear_stats();
        push(0, 16'h003C, 1'b0);
        push(0, 16'h00C3, 1'b1);
        repeat (90) step();
        checks++; if (ndone[0] != 2) begin errors++; $display("FAIL b2b_ndone got %0d want 2", ndone[0]); end
        checks++; if (nbits[0] != 16) begin errors++; $display("FAIL b2b_nbits got %0d want 16", nbits[0]); end
        checks++; if (bits[0][15:0] !== 16'h3CC3) begin errors++; $display("FAIL b2b_bits got 0x%0h want 0x3cc3", bits[0][15:0]); end
        checks++; if (acc_t[0][1] - acc_t[0][0] != 37) begin errors++; $display("FAIL b2b_acc_gap got %0d want 37", acc_t[0][1] - acc_t[0][0]); end
        checks++; if (done_t[0][1] - done_t[0][0] != 37) begin errors++; $display("FAIL b2b_done_gap got %0d want 37", done_t[0][1] - done_t[0][0]); end
        checks++; if (nfall[0] != 2) begin errors++; $display("FAIL b2b_cs_falls got %0d want 2", nfall[0]); end
        checks++; if (fall_t[0][1] - rise_t[0][0] != 3) begin errors++; $display("FAIL b2b_cs_high got %0d want 3", fall_t[0][1] - rise_t[0][0]); end
        checks++; if (dc[0] !== 1'b1) begin errors++; $display("FAIL b2b_dc got %b want 1", dc[0]); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            valid[i] = 1'b0;
            data[i]  = '0;
            dc_in[i] = 1'b0;
        end
        clear_stats();
        repeat (3) step();
        test_reset();
        test_basic();
        test_wide();
        test_reset_mid();
`ifdef SPI_BURST_EN
        test_burst();
`else
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
